// File: rtl/cpu_branch_pkg.sv
// cpu_branch_pkg: shared encodings and defaults for the branch sequencer slice.
// Contents: data/offset width defaults, reset PC default, op and C2 condition
// encodings, FSM state codes, the captured request payload, and a reference
// condition function for the CON evaluator.
package cpu_branch_pkg;

   localparam int unsigned DATA_W_DEF   = 32;
   localparam int unsigned OFFSET_W_DEF = 19;
   localparam int unsigned OP_W         = 2;
   localparam int unsigned C2_W         = 4;
   localparam int unsigned STATE_W      = 3;
   localparam int unsigned STAT_W       = 16;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // Operation encodings carried on op
   localparam logic [OP_W-1:0] OP_NOP = 2'b00;
   localparam logic [OP_W-1:0] OP_BR  = 2'b01;
   localparam logic [OP_W-1:0] OP_JR  = 2'b10;
   localparam logic [OP_W-1:0] OP_JAL = 2'b11;

   // IR[22:19] condition encodings
   localparam logic [C2_W-1:0] C2_ZR = 4'd0;
   localparam logic [C2_W-1:0] C2_NZ = 4'd1;
   localparam logic [C2_W-1:0] C2_PL = 4'd2;
   localparam logic [C2_W-1:0] C2_MI = 4'd3;

   // Sequencer states
   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_COND   = 3'd1;
   localparam logic [STATE_W-1:0] ST_LATCH  = 3'd2;
   localparam logic [STATE_W-1:0] ST_LINK   = 3'd3;
   localparam logic [STATE_W-1:0] ST_UPDATE = 3'd4;
   localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

   // Request fields captured with start
   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [C2_W-1:0] c2;
   } br_req_t;

   // Reference CON evaluation of a register value against a C2 code
   function automatic logic cond_met(input logic [C2_W-1:0] c2,
                                     input logic [DATA_W_DEF-1:0] value);
      case (c2)
         C2_ZR:   return (value == '0);
         C2_NZ:   return (value != '0);
         C2_PL:   return !value[DATA_W_DEF-1];
         C2_MI:   return value[DATA_W_DEF-1];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: request, condition-evaluator and PC/link signals of the
// branch sequencer.
//   slave  : sequencer side (branch_sequencer)
//   master : requester / evaluator side
// taken_count / not_taken_count are always present; they read 0 unless the
// design is built with BRANCH_STATS_EN.
interface branch_sequencer_if
   import cpu_branch_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned OFFSET_W = OFFSET_W_DEF
);
   logic                start;
   logic [OP_W-1:0]     op;
   logic [C2_W-1:0]     c2;
   logic [OFFSET_W-1:0] offset;
   logic [DATA_W-1:0]   ra_value;
   logic                pc_inc;
   logic                con_en;
   logic [C2_W-1:0]     con_c2;
   logic                con_value;
   logic [DATA_W-1:0]   pc;
   logic                link_we;
   logic [DATA_W-1:0]   link_value;
   logic                busy;
   logic                done;
   logic                branch_taken;
   logic                con_ff;
   logic [STAT_W-1:0]   taken_count;
   logic [STAT_W-1:0]   not_taken_count;

   modport slave (
      input  start, op, c2, offset, ra_value, pc_inc, con_value,
      output con_en, con_c2, pc, link_we, link_value, busy, done,
             branch_taken, con_ff, taken_count, not_taken_count
   );

   modport master (
      output start, op, c2, offset, ra_value, pc_inc, con_value,
      input  con_en, con_c2, pc, link_we, link_value, busy, done,
             branch_taken, con_ff, taken_count, not_taken_count
   );
endinterface

// File: rtl/branch_target_adder.sv
// branch_target_adder: combinational branch target, base + sign-extended offset.
//   base     : current PC
//   offset   : signed branch offset, MSB is the sign bit
//   target_c : base + sext(offset), wrapping modulo 2^DATA_W
module branch_target_adder #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned OFFSET_W = 19
) (
   input  logic [DATA_W-1:0]   base,
   input  logic [OFFSET_W-1:0] offset,
   output logic [DATA_W-1:0]   target_c
);
   logic [DATA_W-1:0] offset_sext;

   assign offset_sext = {{(DATA_W - OFFSET_W){offset[OFFSET_W-1]}}, offset};
   assign target_c    = base + offset_sext;
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: strobes the condition evaluator, latches CON, and sequences
// PC updates for br / jr / jal; owns the architectural PC including the
// sequential fetch increment, and issues the R15 link write for jal.
// Ports:
//   clock   : system clock, rising edge
//   clear_n : asynchronous active-low reset
//   bus     : branch_sequencer_if.slave (start/op/c2/offset/ra_value/pc_inc in,
//             con_en/con_c2 to evaluator, con_value back, pc, link_we/link_value,
//             busy, done, branch_taken, con_ff, taken_count, not_taken_count)
// Build option: BRANCH_STATS_EN adds saturating taken / not-taken BR counters;
// without it both count outputs are tied to 0.
module branch_sequencer
   import cpu_branch_pkg::*;
#(
   parameter int unsigned       DATA_W   = DATA_W_DEF,
   parameter int unsigned       OFFSET_W = OFFSET_W_DEF,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF)
) (
   input logic               clock,
   input logic               clear_n,
   branch_sequencer_if.slave bus
);
   logic [STATE_W-1:0]  state;
   logic [STATE_W-1:0]  state_nx;
   br_req_t             req_q;
   logic [OFFSET_W-1:0] offset_q;
   logic [DATA_W-1:0]   pc_q;
   logic [DATA_W-1:0]   link_value_q;
   logic [DATA_W-1:0]   target_c;
   logic                con_ff_q;
   logic                taken_q;
   logic                con_en_q;
   logic                link_we_q;
   logic                done_q;
   logic                busy_q;

   branch_target_adder #(
      .DATA_W   (DATA_W),
      .OFFSET_W (OFFSET_W)
   ) u_target (
      .base     (pc_q),
      .offset   (offset_q),
      .target_c (target_c)
   );

   // State register
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_NOP:  state_nx = ST_DONE;
                  OP_BR:   state_nx = ST_COND;
                  OP_JR:   state_nx = ST_UPDATE;
                  default: state_nx = ST_LINK;
               endcase
            end
         end
         ST_COND:   state_nx = ST_LATCH;
         ST_LATCH:  state_nx = ST_UPDATE;
         ST_LINK:   state_nx = ST_UPDATE;
         ST_UPDATE: state_nx = ST_DONE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they coincide with it
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         con_en_q  <= 1'b0;
         link_we_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         con_en_q  <= (state_nx == ST_COND);
         link_we_q <= (state_nx == ST_LINK);
         done_q    <= (state_nx == ST_DONE);
         busy_q    <= (state_nx != ST_IDLE);
      end
   end

   // Request capture, PC, CON flip-flop, link value and branch result
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         req_q        <= '0;
         offset_q     <= '0;
         pc_q         <= RESET_PC;
         link_value_q <= '0;
         con_ff_q     <= 1'b0;
         taken_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // start has priority; a simultaneous pc_inc is dropped
               if (bus.start) begin
                  req_q    <= '{op: bus.op, c2: bus.c2};
                  offset_q <= bus.offset;
               end else if (bus.pc_inc) begin
                  pc_q <= pc_q + DATA_W'(1);
               end
               // pc is not modified on the cycle that enters LINK
               if (state_nx == ST_LINK) link_value_q <= pc_q;
            end
            ST_LATCH: con_ff_q <= bus.con_value;
            ST_UPDATE: begin
               if (req_q.op == OP_BR) begin
                  taken_q <= con_ff_q;
                  if (con_ff_q) pc_q <= target_c;
               end else begin
                  taken_q <= 1'b1;
                  pc_q    <= bus.ra_value;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0] taken_cnt_q;
   logic [STAT_W-1:0] not_taken_cnt_q;

   // Saturating BR outcome counters, bumped as DONE retires
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         taken_cnt_q     <= '0;
         not_taken_cnt_q <= '0;
      end else if (state == ST_DONE && req_q.op == OP_BR) begin
         if (taken_q) begin
            if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + STAT_W'(1);
         end else begin
            if (not_taken_cnt_q != '1) not_taken_cnt_q <= not_taken_cnt_q + STAT_W'(1);
         end
      end
   end

   assign bus.taken_count     = taken_cnt_q;
   assign bus.not_taken_count = not_taken_cnt_q;
`else
   assign bus.taken_count     = '0;
   assign bus.not_taken_count = '0;
`endif

   assign bus.con_en       = con_en_q;
   assign bus.con_c2       = req_q.c2;
   assign bus.pc           = pc_q;
   assign bus.link_we      = link_we_q;
   assign bus.link_value   = link_value_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.branch_taken = taken_q;
   assign bus.con_ff       = con_ff_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed bench for branch_sequencer with a scoreboard of
// expected PC / branch result / latency per operation and a CON evaluator model.
module tb_branch_sequencer;
   import cpu_branch_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned OW = 19;

   typedef struct {
      logic [DW-1:0] pc;
      logic          taken;
      bit            chk_taken;
      int            lat;
      int            links;
      int            conds;
      logic [DW-1:0] link_val;
   } exp_t;

   logic clock = 1'b0;
   logic clear_n = 1'b0;

   int checks = 0;
   int errors = 0;

   int con_cnt = 0;
   int link_cnt = 0;
   int done_cnt = 0;
   logic [DW-1:0] last_link = '0;

   logic [DW-1:0] model_pc = '0;
   exp_t sb[$];

   branch_sequencer_if #(.DATA_W(DW), .OFFSET_W(OW)) bus ();

   branch_sequencer #(
      .DATA_W   (DW),
      .OFFSET_W (OW),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // Condition evaluator: CON_out valid the cycle after CONin
   always @(posedge clock or negedge clear_n) begin
      if (!clear_n)        bus.con_value <= 1'b0;
      else if (bus.con_en) bus.con_value <= cond_met(bus.con_c2, bus.ra_value);
   end

   // Pulse monitor, sampled mid-cycle
   always @(negedge clock) begin
      if (bus.con_en) con_cnt <= con_cnt + 1;
      if (bus.done)   done_cnt <= done_cnt + 1;
      if (bus.link_we) begin
         link_cnt  <= link_cnt + 1;
         last_link <= bus.link_value;
      end
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue one operation, wait (bounded) for done, then score it.
   // dup: also raise pc_inc with start, and re-request start+pc_inc while busy.
   task automatic run_op(input logic [OP_W-1:0] o, input logic [C2_W-1:0] c,
                         input logic [OW-1:0] off, input logic [DW-1:0] ra, input bit dup);
      exp_t e;
      exp_t got;
      int lat, c0, l0, d0;
      e.pc = model_pc; e.taken = 1'b0; e.chk_taken = (o != OP_NOP);
      e.links = 0; e.conds = 0; e.link_val = model_pc; e.lat = 1;
      case (o)
         OP_BR: begin
            e.lat = 4; e.conds = 1; e.taken = cond_met(c, ra);
            if (e.taken) e.pc = model_pc + {{(DW-OW){off[OW-1]}}, off};
         end
         OP_JR:  begin e.lat = 2; e.pc = ra; e.taken = 1'b1; end
         OP_JAL: begin e.lat = 3; e.pc = ra; e.taken = 1'b1; e.links = 1; end
         default: ;
      endcase
      sb.push_back(e);
      c0 = con_cnt; l0 = link_cnt; d0 = done_cnt;
      bus.op = o; bus.c2 = c; bus.offset = off; bus.ra_value = ra;
      bus.start = 1'b1; bus.pc_inc = dup;
      step();
      lat = 1;
      while (bus.done !== 1'b1 && lat < 16) begin
         if (o == OP_BR && lat == 1) begin
            check("con_en_cycle1", bus.con_en, 1);
            check("con_c2", bus.con_c2, c);
         end
         bus.start  = dup && lat <= 2;
         bus.pc_inc = dup && lat <= 2;
         if (dup) bus.op = OP_JAL;
         step();
         lat++;
      end
      bus.start = 1'b0; bus.pc_inc = 1'b0;
      got = sb.pop_front();
      check("latency", lat, got.lat);
      check("pc_at_done", bus.pc, got.pc);
      if (got.chk_taken) check("branch_taken", bus.branch_taken, got.taken);
      if (o == OP_BR) check("con_ff", bus.con_ff, got.taken);
      step(); step();
      check("done_pulses", done_cnt - d0, 1);
      check("link_pulses", link_cnt - l0, got.links);
      check("con_pulses", con_cnt - c0, got.conds);
      check("pc_after", bus.pc, got.pc);
      check("busy_after", bus.busy, 0);
      if (got.links != 0) check("link_value", last_link, got.link_val);
      model_pc = got.pc;
   endtask

   initial begin
      int d0;
      bus.start = 1'b0; bus.op = OP_NOP; bus.c2 = '0; bus.offset = '0;
      bus.ra_value = '0; bus.pc_inc = 1'b0;
      clear_n = 1'b0;
      step(); step();

      // Reset values
      check("rst_pc", bus.pc, 0);
      check("rst_con_ff", bus.con_ff, 0);
      check("rst_taken", bus.branch_taken, 0);
      check("rst_link_value", bus.link_value, 0);
      check("rst_con_en", bus.con_en, 0);
      check("rst_link_we", bus.link_we, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);

      // Sequential fetch increment
      clear_n = 1'b1;
      bus.pc_inc = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check("pc_inc", bus.pc, i);
         check("pc_inc_busy", bus.busy, 0);
      end
      bus.pc_inc = 1'b0;
      check("pc_inc_no_done", done_cnt, 0);
      model_pc = 32'd3;

      run_op(OP_JR,  C2_ZR, 19'h0,     32'h0000_0100, 1'b0);
      run_op(OP_BR,  C2_ZR, 19'h00010, 32'h0000_0000, 1'b0);  // taken, 0x110
      run_op(OP_JR,  C2_ZR, 19'h0,     32'h0000_0100, 1'b0);
      run_op(OP_BR,  C2_MI, 19'h7FFF0, 32'h0000_0005, 1'b0);  // not taken
      run_op(OP_BR,  C2_MI, 19'h7FFF0, 32'h8000_0000, 1'b0);  // taken, 0xF0
      run_op(OP_JR,  C2_ZR, 19'h0,     32'h0000_0040, 1'b0);
      run_op(OP_JAL, C2_ZR, 19'h0,     32'h0000_2000, 1'b0);  // link 0x40
      run_op(OP_NOP, C2_ZR, 19'h0,     32'h0000_2000, 1'b0);

      // PC increment wraps at the top of the address space
      run_op(OP_JR,  C2_ZR, 19'h0,     32'hFFFF_FFFF, 1'b0);
      bus.pc_inc = 1'b1;
      step();
      bus.pc_inc = 1'b0;
      check("pc_wrap", bus.pc, 0);
      model_pc = '0;

      // start+pc_inc together, then start/pc_inc while busy: both ignored
      run_op(OP_BR,  C2_ZR, 19'h00020, 32'h0000_0000, 1'b1);  // taken, 0x20

`ifdef BRANCH_STATS_EN
      check("taken_count", 32'(bus.taken_count), 3);
      check("not_taken_count", 32'(bus.not_taken_count), 1);
`endif

      // Reset during LATCH of a BR aborts with no done
      check("con_ff_before_abort", bus.con_ff, 1);
      d0 = done_cnt;
      bus.op = OP_BR; bus.c2 = C2_NZ; bus.offset = 19'h00005; bus.ra_value = '0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      check("abort_busy_in_latch", bus.busy, 1);
      clear_n = 1'b0;
      #1;
      check("abort_pc", bus.pc, 0);
      check("abort_con_ff", bus.con_ff, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_taken", bus.branch_taken, 0);
      check("abort_taken_count", 32'(bus.taken_count), 0);
      check("abort_not_taken_count", 32'(bus.not_taken_count), 0);
      step();
      clear_n = 1'b1;
      repeat (4) step();
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_idle", bus.busy, 0);
      check("abort_pc_held", bus.pc, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
